// File: rtl/aoi_vector_checker_if.sv
// Bundles the stimulus/response and status signals of the AOI sweep checker.
// The master modport is the checker; the slave modport is the gate/environment side.
interface aoi_vector_checker_if #(
    parameter int ERR_W = 5
);
    logic             start;
    logic             a;
    logic             b;
    logic             c;
    logic             d;
    logic             y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [3:0]       first_err_vec;
    logic             first_err_valid;

    modport master (
        input  start, y,
        output a, b, c, d, busy, done, pass, err_count, first_err_vec, first_err_valid
    );

    modport slave (
        output start, y,
        input  a, b, c, d, busy, done, pass, err_count, first_err_vec, first_err_valid
    );
endinterface

// File: rtl/aoi_vector_checker.sv
// Sweeps all 16 input vectors of an AND-OR-INVERT gate, holds each for HOLD_CYCLES,
// samples y at the end of each window and reports mismatches against the golden AOI.
module aoi_vector_checker #(
    parameter int HOLD_CYCLES = 10,
    parameter int ERR_W       = 5
) (
    input logic                    clk,
    input logic                    rst,
    aoi_vector_checker_if.master   bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int               CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t           state_q, state_d;
    logic [3:0]       vec_q, vec_d;
    logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] errCount_q, errCount_d;
    logic [3:0]       firstErrVec_q, firstErrVec_d;
    logic             firstErrValid_q, firstErrValid_d;

    logic expected;
    logic mismatch;
    logic sampleEdge;

    // Golden value comes from the registered vector, i.e. exactly what the gate sees.
    // Case-inequality makes an X/Z response count as a failure in simulation.
    always_comb begin
        expected   = ~((vec_q[3] & vec_q[2]) | (vec_q[1] & vec_q[0]));
        mismatch   = (bus.y !== expected);
        sampleEdge = (holdCnt_q == LAST_CNT);

        state_d         = state_q;
        vec_d           = vec_q;
        holdCnt_d       = holdCnt_q;
        busy_d          = busy_q;
        done_d          = done_q;
        pass_d          = pass_q;
        errCount_d      = errCount_q;
        firstErrVec_d   = firstErrVec_q;
        firstErrValid_d = firstErrValid_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d         = RUN;
                    vec_d           = 4'h0;
                    holdCnt_d       = '0;
                    busy_d          = 1'b1;
                    done_d          = 1'b0;
                    pass_d          = 1'b0;
                    errCount_d      = '0;
                    firstErrVec_d   = 4'h0;
                    firstErrValid_d = 1'b0;
                end
            end
            RUN: begin
                holdCnt_d = holdCnt_q + CNT_W'(1);
                if (sampleEdge) begin
                    if (mismatch) begin
                        if (errCount_q != ERR_MAX) begin
                            errCount_d = errCount_q + ERR_W'(1);
                        end
                        if (!firstErrValid_q) begin
                            firstErrVec_d   = vec_q;
                            firstErrValid_d = 1'b1;
                        end
                    end
                    holdCnt_d = '0;
                    if (vec_q == 4'hF) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (errCount_q == '0) && !mismatch;
                        vec_d   = 4'h0;
                    end else begin
                        vec_d = vec_q + 4'h1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state and outputs are registered and cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            vec_q           <= 4'h0;
            holdCnt_q       <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            errCount_q      <= '0;
            firstErrVec_q   <= 4'h0;
            firstErrValid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            vec_q           <= vec_d;
            holdCnt_q       <= holdCnt_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
            errCount_q      <= errCount_d;
            firstErrVec_q   <= firstErrVec_d;
            firstErrValid_q <= firstErrValid_d;
        end
    end

    assign bus.a               = vec_q[3];
    assign bus.b               = vec_q[2];
    assign bus.c               = vec_q[1];
    assign bus.d               = vec_q[0];
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = pass_q;
    assign bus.err_count       = errCount_q;
    assign bus.first_err_vec   = firstErrVec_q;
    assign bus.first_err_valid = firstErrValid_q;

endmodule
